// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
// Signal suffixes are named from the divider's point of view.
interface seq_divider_if #(
    parameter int width_p = 8
);
    logic               valid_i;
    logic               ready_o;
    logic [width_p-1:0] dividend_i;
    logic [width_p-1:0] divisor_i;
    logic               valid_o;
    logic               ready_i;
    logic [width_p-1:0] quotient_o;
    logic [width_p-1:0] remainder_o;
    logic               div_by_zero_o;

    modport slave (
        input  valid_i, dividend_i, divisor_i, ready_i,
        output ready_o, valid_o, quotient_o, remainder_o, div_by_zero_o
    );

    modport master (
        output valid_i, dividend_i, divisor_i, ready_i,
        input  ready_o, valid_o, quotient_o, remainder_o, div_by_zero_o
    );
endinterface

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, MSB first.
// Operands in and results out over valid/ready; divide-by-zero just runs the algorithm.
module seq_divider #(
    parameter int width_p = 8
) (
    input  logic         clk_i,
    input  logic         reset_n_i,
    seq_divider_if.slave bus
);
    localparam int cnt_w_lp = $clog2(width_p + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_reg;
    logic [width_p-1:0]  q_reg;
    logic [width_p-1:0]  d_reg;
    logic [width_p-1:0]  r_reg;
    logic [cnt_w_lp-1:0] count_reg;
    logic                dbz_reg;

    logic [width_p:0]    trial;
    logic [width_p-1:0]  diff;
    logic                fits;

    // Only the low width_p bits of the partial remainder ever feed the next
    // trial, and after a subtraction the result is below D, so the stored
    // remainder and the difference can both be kept at width_p bits.
    always_comb begin
        trial = {r_reg, q_reg[width_p-1]};
        fits  = (trial >= {1'b0, d_reg});
        diff  = trial[width_p-1:0] - d_reg;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg <= IDLE;
            q_reg     <= '0;
            d_reg     <= '0;
            r_reg     <= '0;
            count_reg <= '0;
            dbz_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.valid_i) begin
                        q_reg     <= bus.dividend_i;
                        d_reg     <= bus.divisor_i;
                        r_reg     <= '0;
                        count_reg <= cnt_w_lp'(width_p);
                        dbz_reg   <= (bus.divisor_i == '0);
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    q_reg     <= {q_reg[width_p-2:0], fits};
                    r_reg     <= fits ? diff : trial[width_p-1:0];
                    count_reg <= count_reg - cnt_w_lp'(1);
                    if (count_reg == cnt_w_lp'(1)) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (bus.ready_i) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // ready_o is gated by reset so it drops the moment reset asserts.
    assign bus.ready_o       = reset_n_i && (state_reg == IDLE);
    assign bus.valid_o       = (state_reg == DONE);
    assign bus.quotient_o    = q_reg;
    assign bus.remainder_o   = r_reg;
    assign bus.div_by_zero_o = dbz_reg;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table, backpressure, mid-op reset,
// and a back-to-back run checked against a multiply-back reference.
module tb_seq_divider;
    localparam int W = 8;
    localparam int N_RAND = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    seq_divider_if #(.width_p(W)) bus ();

    seq_divider #(.width_p(W)) dut (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Presents one operand pair with ready_i low and waits for valid_o.
    // lat counts clock edges from acceptance (inclusive) to valid_o.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic z, output int lat);
        @(negedge clk);
        check("ready_before_accept", 32'(bus.ready_o), 32'd1);
        bus.dividend_i = a;
        bus.divisor_i  = b;
        bus.valid_i    = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        while (!bus.valid_o && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        q = bus.quotient_o;
        r = bus.remainder_o;
        z = bus.div_by_zero_o;
    endtask

    task automatic consume();
        bus.ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.ready_i = 1'b0;
        check("valid_after_consume", 32'(bus.valid_o), 32'd0);
        check("ready_after_consume", 32'(bus.ready_o), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] q, r;
        logic         z;
        int           lat;
        int           edges;
        int           guard;

        vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
        vecs[1] = '{8'hA5,  8'd0,   8'hFF,  8'hA5,  1'b1};
        vecs[2] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
        vecs[3] = '{8'd0,   8'd13,  8'd0,   8'd0,   1'b0};
        vecs[4] = '{8'd5,   8'd200, 8'd0,   8'd5,   1'b0};
        vecs[5] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
        vecs[6] = '{8'd200, 8'd9,   8'd22,  8'd2,   1'b0};
        vecs[7] = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1};

        bus.valid_i    = 1'b0;
        bus.ready_i    = 1'b0;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;

        // Reset state
        #12;
        check("reset_ready", 32'(bus.ready_o), 32'd0);
        check("reset_valid", 32'(bus.valid_o), 32'd0);
        check("reset_q", 32'(bus.quotient_o), 32'd0);
        check("reset_r", 32'(bus.remainder_o), 32'd0);
        check("reset_dbz", 32'(bus.div_by_zero_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_release", 32'(bus.ready_o), 32'd1);

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, q, r, z, lat);
            $display("vec %0d: %0d/%0d -> q=%0d r=%0d dbz=%0d lat=%0d",
                     i, vecs[i].a, vecs[i].b, q, r, z, lat);
            check("vec_latency", 32'(lat), 32'(W + 1));
            check("vec_quotient", 32'(q), 32'(vecs[i].q));
            check("vec_remainder", 32'(r), 32'(vecs[i].r));
            check("vec_dbz", 32'(z), 32'(vecs[i].z));
            consume();
        end

        // Backpressure: result held, new operands ignored
        run_op(8'd37, 8'd5, q, r, z, lat);
        $display("bp: 37/5 -> q=%0d r=%0d lat=%0d", q, r, lat);
        check("bp_quotient", 32'(q), 32'd7);
        check("bp_remainder", 32'(r), 32'd2);
        for (int c = 0; c < 20; c++) begin
            bus.dividend_i = 8'd1;
            bus.divisor_i  = 8'd1;
            bus.valid_i    = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("bp_hold", {28'd0, bus.valid_o, bus.ready_o, 2'b00} | 32'(0),
                  {28'd0, 1'b1, 1'b0, 2'b00});
            check("bp_stable", {16'd0, bus.quotient_o, bus.remainder_o}, {16'd0, 8'd7, 8'd2});
        end
        bus.valid_i = 1'b0;
        consume();
        @(posedge clk);
        @(negedge clk);
        check("bp_no_stray_accept", 32'(bus.ready_o), 32'd1);

        // Reset asserted between edges four cycles into BUSY
        @(negedge clk);
        bus.dividend_i = 8'd100;
        bus.divisor_i  = 8'd7;
        bus.valid_i    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.valid_o), 32'd0);
        check("midrst_ready", 32'(bus.ready_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_release_ready", 32'(bus.ready_o), 32'd1);
        run_op(8'd200, 8'd9, q, r, z, lat);
        $display("post-reset: 200/9 -> q=%0d r=%0d lat=%0d", q, r, lat);
        check("midrst_latency", 32'(lat), 32'(W + 1));
        check("midrst_quotient", 32'(q), 32'd22);
        check("midrst_remainder", 32'(r), 32'd2);
        consume();

        // Back-to-back with ready_i high, multiply-back reference
        bus.ready_i = 1'b1;
        edges = 0;
        for (int i = 0; i < N_RAND; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom_range(255));
            b = (i % 17 == 0) ? '0 : W'($urandom_range(255));
            bus.dividend_i = a;
            bus.divisor_i  = b;
            bus.valid_i    = 1'b1;
            guard = 0;
            while (!bus.ready_o && guard < 40) begin
                @(posedge clk);
                edges++;
                guard++;
                @(negedge clk);
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
            bus.valid_i = 1'b0;
            guard = 0;
            while (!bus.valid_o && guard < 40) begin
                @(posedge clk);
                edges++;
                guard++;
                @(negedge clk);
            end
            q = bus.quotient_o;
            r = bus.remainder_o;
            z = bus.div_by_zero_o;
            $display("rand %0d: %0d/%0d -> q=%0d r=%0d dbz=%0d", i, a, b, q, r, z);
            if (b != 0) begin
                check("rand_invariant", 32'(q) * 32'(b) + 32'(r), 32'(a));
                check("rand_rem_lt_div", 32'(r < b), 32'd1);
                check("rand_dbz", 32'(z), 32'd0);
            end else begin
                check("rand_dbz_result", {15'd0, z, q, r}, {15'd0, 1'b1, 8'hFF, a});
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        bus.ready_i = 1'b0;
        check("throughput_edges", 32'(edges), 32'(N_RAND * (W + 2)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative unsigned restoring divider; the inverse of the combinational multiplier in the arithmetic lab set.
- Accepts a dividend/divisor pair over a valid/ready handshake and produces one quotient bit per cycle, MSB first.
- Presents quotient and remainder over a valid/ready handshake.
- Results satisfy quotient*divisor + remainder == dividend, so the existing multiplier can check them.

Parameters:
width_p, 8, operand, quotient and remainder width in bits (>=2)

Ports:
clk_i  input  1  clock; all state changes on rising edge
reset_n_i  input  1  asynchronous active-low reset
valid_i  input  1  operands on dividend_i/divisor_i are valid
ready_o  output  1  block can accept operands
dividend_i  input  width_p  unsigned dividend
divisor_i  input  width_p  unsigned divisor
valid_o  output  1  quotient_o/remainder_o/div_by_zero_o valid
ready_i  input  1  consumer takes result
quotient_o  output  width_p  unsigned quotient
remainder_o  output  width_p  unsigned remainder
div_by_zero_o  output  1  latched divisor was zero

Behaviour:
- Reset: asserting reset_n_i low forces the following immediately, regardless of clk_i:
  - state IDLE, iteration counter 0
  - ready_o=0 while reset is held; ready_o=1 after release (IDLE)
  - valid_o=0, quotient_o=0, remainder_o=0, div_by_zero_o=0
- Reset mid-operation aborts the operation with no output. The first operand accepted after release is processed normally.
- States:
  - IDLE: ready_o=1, valid_o=0. On an edge with valid_i=1:
    - latch dividend into shift register Q
    - latch divisor into D
    - clear partial remainder R (width_p+1 bits)
    - set counter to width_p
    - set div_by_zero flag = (divisor_i==0)
    - go to BUSY
    - With valid_i=0, stay in IDLE.
  - BUSY: ready_o=0, valid_o=0. Each edge performs one step:
    - T = {R[width_p-1:0], Q[MSB]}
    - shift Q left
    - if T >= {1'b0,D}: R = T-D, Q[0]=1; else R = T, Q[0]=0
    - decrement counter
    - The step in which the counter goes 1->0 also transitions to DONE.
    - valid_i and ready_i are ignored.
  - DONE: valid_o=1, ready_o=0. quotient_o=Q, remainder_o=R[width_p-1:0], div_by_zero_o=flag, all held stable.
    - On an edge with ready_i=1, go to IDLE and valid_o drops.
    - With ready_i=0, hold indefinitely.
- Latency and throughput:
  - Operand acceptance edge t; iteration edges t+1..t+width_p; valid_o high after edge t+width_p (width_p+1 edges total).
  - Result consumed at edge u; next operand acceptable earliest at edge u+1 (one IDLE cycle).
  - Maximum throughput is one operation per width_p+2 cycles.
- Outputs quotient_o/remainder_o/div_by_zero_o are don't-care when valid_o=0; the bench checks them only while valid_o=1.
- Divide by zero: no special path; the algorithm runs unchanged and yields quotient = all ones and remainder = dividend. div_by_zero_o=1. Latency is identical.
- Arithmetic: all unsigned. R never exceeds D-1 after a step, so the remainder fits in width_p bits. No overflow is possible for a nonzero divisor.
- Simultaneous events:
  - valid_i while not IDLE: ignored; the upstream holds the operands until ready_o.
  - ready_i without valid_o: ignored.
- Required invariant: valid_o && !div_by_zero_o implies quotient_o*divisor + remainder_o == dividend, and remainder_o < divisor.

Test Plan:
- Basic: reset, accept dividend=100 divisor=7 -> valid_o exactly 9 edges after acceptance, quotient_o=14, remainder_o=2, div_by_zero_o=0.
- Divide by zero: dividend=0xA5 divisor=0 -> quotient_o=0xFF, remainder_o=0xA5, div_by_zero_o=1, same 9-edge latency.
- Boundaries:
  - 255/1 -> q=255 r=0
  - 0/13 -> q=0 r=0
  - 5/200 -> q=0 r=5
  - 255/255 -> q=1 r=0
- Backpressure: hold ready_i=0 for 20 cycles after valid_o -> outputs stable, ready_o=0, and new valid_i ignored. Raise ready_i -> valid_o falls next edge and ready_o=1.
- Reset mid-operation: assert reset_n_i between clock edges 4 cycles into BUSY -> immediate valid_o=0 and ready_o=0. Release -> ready_o=1. A fresh 200/9 returns q=22 r=2.
- Exhaustive: all 65536 pairs back-to-back with ready_i=1; check the invariant using a multiplier reference model and count cycles per operation = width_p+2.
